// File: rtl/complex_alu_pipe.sv
// complex_alu_pipe: 3-stage complex add/sub/mul/conj-mul ALU with
// valid/ready on both sides, full stall on back-pressure, op counter.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, mode, a..d;
// out_valid/out_ready, re, im, ovf; op_count (results consumed).
// Macro COMPLEX_ALU_SAT_EN: saturate results; otherwise wrap.
module complex_alu_pipe #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  re,
  output logic signed [OUT_W-1:0]  im,
  output logic                     ovf,
  output logic [CNT_W-1:0]         op_count
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  // S1: operand capture
  logic                     v1;
  logic [1:0]               m1;
  logic signed [DATA_W-1:0] a1, b1, c1, d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      m1 <= mode;
      a1 <= a;
      b1 <= b;
      c1 <= c;
      d1 <= d;
    end
  end

  // S2: every mode reduces to x +/- y per component,
  // so the last stage is a single add/sub per lane.
  logic signed [PW-1:0] ac, bd, ad, bc;
  logic signed [PW-1:0] rx, ry, ix, iy;
  logic                 rsb, isb;

  assign ac = PW'(a1) * PW'(c1);
  assign bd = PW'(b1) * PW'(d1);
  assign ad = PW'(a1) * PW'(d1);
  assign bc = PW'(b1) * PW'(c1);

  always_comb begin
    rx  = PW'(a1);
    ry  = PW'(c1);
    ix  = PW'(b1);
    iy  = PW'(d1);
    rsb = 1'b0;
    isb = 1'b0;
    unique case (m1)
      2'b00: begin
        rsb = 1'b0;
        isb = 1'b0;
      end
      2'b01: begin
        rsb = 1'b1;
        isb = 1'b1;
      end
      2'b10: begin
        rx  = ac;
        ry  = bd;
        rsb = 1'b1;
        ix  = ad;
        iy  = bc;
        isb = 1'b0;
      end
      2'b11: begin
        rx  = ac;
        ry  = bd;
        rsb = 1'b0;
        ix  = bc;
        iy  = ad;
        isb = 1'b1;
      end
    endcase
  end

  logic                 v2;
  logic signed [PW-1:0] rx2, ry2, ix2, iy2;
  logic                 rsb2, isb2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2   <= v1;
      rx2  <= rx;
      ry2  <= ry;
      ix2  <= ix;
      iy2  <= iy;
      rsb2 <= rsb;
      isb2 <= isb;
    end
  end

  // S3: combine at full precision, then narrow
  logic signed [SW-1:0] rsum, isum;
  logic [OUT_W:0]       rn, in_n;

  assign rsum = rsb2 ? SW'(rx2) - SW'(ry2)
                     : SW'(rx2) + SW'(ry2);
  assign isum = isb2 ? SW'(ix2) - SW'(iy2)
                     : SW'(ix2) + SW'(iy2);

  // {overflow, value}; overflow means the value is not a
  // sign-extension of its low OUT_W bits.
  function automatic logic [OUT_W:0] narrow(
    input logic signed [SW-1:0] v
  );
    logic signed [OUT_W-1:0] t;
    logic                    o;
    t = v[OUT_W-1:0];
    o = (SW'(t) != v);
`ifdef COMPLEX_ALU_SAT_EN
    if (o) begin
      t = v[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                  : {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
`endif
    return {o, t};
  endfunction

  assign rn   = narrow(rsum);
  assign in_n = narrow(isum);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      re        <= '0;
      im        <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        re  <= rn[OUT_W-1:0];
        im  <= in_n[OUT_W-1:0];
        ovf <= rn[OUT_W] | in_n[OUT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_complex_alu_pipe.sv
// tb_complex_alu_pipe: directed vectors with a queue scoreboard
// and an independent output monitor.
module tb_complex_alu_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_ready4;
  logic [1:0]         mode;
  logic signed [15:0] a, b, c, d;
  logic               out_valid, out_valid4;
  logic               out_ready;
  logic signed [15:0] re, im, re4, im4;
  logic               ovf, ovf4;
  logic [15:0]        op_count;
  logic [3:0]         op_count4;

  always #5 clk = ~clk;

  complex_alu_pipe u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .re(re), .im(im), .ovf(ovf),
    .op_count(op_count)
  );

  complex_alu_pipe #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .mode(mode), .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid4), .out_ready(out_ready),
    .re(re4), .im(im4), .ovf(ovf4),
    .op_count(op_count4)
  );

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               ovf;
    int                 cyc;
    bit                 lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act,
                     input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d",
               n, act, req);
    end
  endtask

  // monitor: stability under stall and in-order results
  bit                 held = 1'b0;
  logic signed [15:0] hre, him;
  logic               hovf;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        chk("hold_re", re, hre);
        chk("hold_im", im, him);
        chk("hold_ovf", ovf, hovf);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out re=%0d im=%0d",
                   re, im);
        end else begin
          e = q.pop_front();
          tests++;
          if (re !== e.re || im !== e.im ||
              ovf !== e.ovf || re4 !== e.re ||
              im4 !== e.im) begin
            fails++;
            $display("FAIL result got=%0d,%0d,%0d req=%0d,%0d,%0d",
                     re, im, ovf, e.re, e.im, e.ovf);
          end
          if (e.lat) chk("latency", cyc - e.cyc, 3);
        end
      end
      held = out_valid && !out_ready;
      hre  = re;
      him  = im;
      hovf = ovf;
    end
  end

  task automatic send(input logic [1:0] m,
                      input int av, input int bv,
                      input int cv, input int dv,
                      input int er, input int ei,
                      input bit eo, input bit lat,
                      input bit push);
    int w;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    mode = m;
    a = 16'(av);
    b = 16'(bv);
    c = 16'(cv);
    d = 16'(dv);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout in_ready=%0d required=1",
               in_ready);
    end else if (push) begin
      e.re  = 16'(er);
      e.im  = 16'(ei);
      e.ovf = eo;
      e.cyc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int er[4] = '{11, -5, -12, 60};
  int ei[4] = '{13, -5, 59, 5};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode = 2'b00;
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_re", re, 0);
    chk("rst_im", im, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // single beats, latency checked
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 3, 4, 8, 9, er[i], ei[i], 1'b0, 1'b1, 1'b1);
      idle();
      drain();
    end
    chk("op_count_single", op_count, 4);

    // back-to-back, mixed modes
    do_reset();
    for (int i = 0; i < 4; i++)
      send(2'(i), 3, 4, 8, 9, er[i], ei[i], 1'b0, 1'b1, 1'b1);
    idle();
    drain();
    chk("op_count_b2b", op_count, 4);
    chk("op_count4_b2b", op_count4, 4);

    // back-pressure
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(2'(i), 3, 4, 8, 9, er[i], ei[i],
               1'b0, 1'b0, 1'b1);
      end
      begin
        repeat (5) @(negedge clk);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_in_ready4", in_ready4, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle();
    drain();
    chk("op_count_stall", op_count, 8);

    // full-scale multiply
`ifdef COMPLEX_ALU_SAT_EN
    send(2'b10, 32767, 32767, 32767, 32767,
         0, 32767, 1'b1, 1'b1, 1'b1);
`else
    send(2'b10, 32767, 32767, 32767, 32767,
         0, 2, 1'b1, 1'b1, 1'b1);
`endif
    idle();
    drain();
    chk("op_count_ovf", op_count, 9);

    // reset with two beats in flight
    send(2'b00, 1, 1, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    send(2'b00, 2, 2, 2, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_re", re, 0);
    chk("midrst_im", im, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_op_count", op_count, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_quiet", out_valid, 0);

    // counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++)
      send(2'b00, i, 1, 2, -1, i + 2, 0,
           1'b0, 1'b0, 1'b1);
    idle();
    drain();
    chk("op_count_17", op_count, 17);
    chk("op_count4_wrap", op_count4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/complex_alu_pipe.md
Name: complex_alu_pipe

Overview:
- Parametrised, pipelined complex-number ALU; next generation of the fixed 16-bit complex add/multiply unit.
- Accepts operand pairs (a+bi, c+di) with a per-transaction mode: add, subtract, multiply, conjugate-multiply.
- Signed two's-complement arithmetic, valid/ready handshake on both sides, full-pipeline stall on back-pressure, and a completed-operation counter.
- Sits between the operand source and the downstream consumer in the complex datapath.

Parameters:
- DATA_W, 16: width of each input component (a, b, c, d), signed.
- OUT_W, 16: width of each result component (re, im), signed. Must satisfy OUT_W <= 2*DATA_W+1.
- CNT_W, 16: width of the op_count counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- mode  in  2  00 add, 01 sub, 10 mul, 11 conj-mul.
- a  in  DATA_W  real part, operand 1.
- b  in  DATA_W  imaginary part, operand 1.
- c  in  DATA_W  real part, operand 2.
- d  in  DATA_W  imaginary part, operand 2.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- re  out  OUT_W  real result.
- im  out  OUT_W  imaginary result.
- ovf  out  1  result did not fit OUT_W (see Optional Feature).
- op_count  out  CNT_W  number of results consumed.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, re=0, im=0, ovf=0, op_count=0, all stage valid bits=0. Takes priority over every other event, including mid-pipeline data, which is discarded.
- Accept: a beat transfers when in_valid && in_ready. Consume: a result transfers when out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = !stall, combinational and independent of in_valid.
- Pipeline: 3 register stages (S1 operand capture, S2 products/sums, S3 combine/narrow → outputs). Each stage holds a valid bit.
  - No stall: latency is exactly 3 cycles from accept edge to out_valid=1. Throughput is 1 per cycle.
  - Stall: all stages and outputs hold. re, im and ovf stay stable while out_valid=1 and out_ready=0.
  - Bubbles (in_valid=0) propagate as valid=0. Outputs hold their last values when out_valid=0.
- Arithmetic, full precision internally; products are 2*DATA_W wide, final sums 2*DATA_W+1 wide, sign-extended:
  - add: re=a+c, im=b+d.
  - sub: re=a-c, im=b-d.
  - mul: re=ac-bd, im=ad+bc.
  - conj-mul: re=ac+bd, im=bc-ad.
- Mode is captured at S1 with the operands and travels with its data. Back-to-back beats with different modes are legal.
- Narrowing to OUT_W: see Optional Feature. ovf is per result, valid with out_valid.
- op_count increments by 1 on each consume and wraps from 2^CNT_W-1 to 0. Simultaneous consume and reset: reset wins.
- Simultaneous consume and accept in the same cycle: both occur, with no bubble inserted.

Optional Feature:
- Macro COMPLEX_ALU_SAT_EN.
- Defined: each full-precision component is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. ovf=1 if either component saturated, else 0.
- Undefined: each component is truncated to its low OUT_W bits (wraps). ovf=1 if the discarded upper bits are not a sign-extension of bit OUT_W-1 in either component; the value itself still wraps.
- Both builds have identical timing and handshake.

Test Plan:
- Defaults, out_ready=1, single beats, (3+4i),(8+9i):
  - mode 00 → re=11, im=13.
  - mode 01 → re=-5, im=-5.
  - mode 10 → re=-12, im=59.
  - mode 11 → re=60, im=5.
  - Each appears exactly 3 cycles after accept, ovf=0.
- Four beats back-to-back, one per mode as above → four consecutive out_valid cycles in order; op_count=4 afterwards.
- out_ready=0 for 5 cycles while 4 beats are offered → in_ready drops once out_valid=1. Outputs are held stable, no result is lost or duplicated, and results resume in order when out_ready=1.
- mul, a=b=c=d=16'sh7FFF:
  - With COMPLEX_ALU_SAT_EN → re=0, im=32767, ovf=1.
  - Without → re=0, im=16'h0002, ovf=1.
- rst asserted with 2 beats in flight → next edge out_valid=0, re=im=0, op_count=0, and neither in-flight result ever appears.
- CNT_W=4, 17 consumed results → op_count wraps and reads 1.
